// File: rtl/html_char_streamer_pkg.sv
// Shared character constants, state encoding and whitespace helper for the
// HTML character streamer and its prefetch FIFO.
package html_char_streamer_pkg;

   localparam int CHAR_BITES = 8;

   localparam logic [CHAR_BITES-1:0] CHAR_NUL = 8'h00;
   localparam logic [CHAR_BITES-1:0] CHAR_CR  = 8'h0D;
   localparam logic [CHAR_BITES-1:0] CHAR_LF  = 8'h0A;
   localparam logic [CHAR_BITES-1:0] CHAR_TAB = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } stream_state_t;

   function automatic logic is_layout_ws(input logic [CHAR_BITES-1:0] c);
      return (c == CHAR_CR) || (c == CHAR_LF) || (c == CHAR_TAB);
   endfunction

endpackage

// File: rtl/char_prefetch_fifo.sv
// Two-entry character FIFO between the ROM fetcher and the presented char.
// Head is always slot0; a simultaneous push and pop keeps the count unchanged.
module char_prefetch_fifo
   import html_char_streamer_pkg::*;
(
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  push,
   input  logic [CHAR_BITES-1:0] push_data,
   input  logic                  pop,
   output logic [CHAR_BITES-1:0] head,
   output logic [1:0]            count
);

   logic [CHAR_BITES-1:0] slot0;
   logic [CHAR_BITES-1:0] slot1;

   assign head = slot0;

   always_ff @(posedge clock) begin
      if (!resetn || flush) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count != 2'd2) begin
                  if (count == 2'd0) slot0 <= push_data;
                  else               slot1 <= push_data;
                  count <= count + 2'd1;
               end
            end
            2'b01: begin
               if (count != 2'd0) begin
                  slot0 <= slot1;
                  count <= count - 2'd1;
               end
            end
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= push_data;
               end else if (count == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/html_char_streamer.sv
// Fetches an HTML document from a synchronous ROM, drops CR/LF/TAB, and
// presents one character at a time to the parser, honouring its pause.
module html_char_streamer
   import html_char_streamer_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DOC_LENGTH = 4096,
   parameter int MIN_HOLD   = 2
)
(
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  pause,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [CHAR_BITES-1:0] mem_data,
   output logic [CHAR_BITES-1:0] char,
   output logic                  parser_enable,
   output logic                  busy,
   output logic                  done
);

   localparam int                  HOLD_W     = $clog2(MIN_HOLD + 1);
   localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0]   HOLD_ONE   = HOLD_W'(1);
   localparam logic [ADDR_WIDTH:0] READ_LIMIT = (ADDR_WIDTH + 1)'(DOC_LENGTH);
   localparam logic [ADDR_WIDTH:0] READ_ONE   = (ADDR_WIDTH + 1)'(1);

   stream_state_t         state;
   logic                  inflight;
   logic                  eof_seen;
   logic [ADDR_WIDTH:0]   reads_issued;
   logic [HOLD_W-1:0]     hold_cnt;

   logic                  fifo_flush;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [CHAR_BITES-1:0] fifo_head;
   logic [1:0]            fifo_count;

   logic active;
   logic nul_now;
   logic eof_now;
   logic fifo_empty;
   logic hold_met;
   logic can_issue;
   logic start_pass;

   // A NUL arriving this cycle must already block the next read, otherwise
   // one stray byte past the terminator would be fetched.
   always_comb begin
      active     = (state == ST_FILL) || (state == ST_STREAM);
      nul_now    = inflight && (mem_data == CHAR_NUL);
      eof_now    = eof_seen || (reads_issued == READ_LIMIT);
      fifo_empty = (fifo_count == 2'd0);
      hold_met   = (hold_cnt >= HOLD_MAX);
      start_pass = start && ((state == ST_IDLE) || (state == ST_DONE));
      fifo_flush = start_pass;
      fifo_push  = inflight && !nul_now && !is_layout_ws(mem_data);
      fifo_pop   = !fifo_empty &&
                   ((state == ST_FILL) ||
                    ((state == ST_STREAM) && hold_met && !pause));
      can_issue  = active && !eof_now && !nul_now &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
   end

   char_prefetch_fifo u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (mem_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         mem_addr      <= '0;
         reads_issued  <= '0;
         inflight      <= 1'b0;
         eof_seen      <= 1'b0;
         hold_cnt      <= '0;
         char          <= '0;
         parser_enable <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         if (nul_now) eof_seen <= 1'b1;
         inflight <= can_issue;
         if (can_issue) begin
            mem_addr     <= reads_issued[ADDR_WIDTH-1:0];
            reads_issued <= reads_issued + READ_ONE;
         end

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_pass) begin
                  state        <= ST_FILL;
                  mem_addr     <= '0;
                  reads_issued <= READ_ONE;
                  inflight     <= 1'b1;
                  eof_seen     <= 1'b0;
                  hold_cnt     <= '0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
               end
            end
            ST_FILL: begin
               if (!fifo_empty) begin
                  char          <= fifo_head;
                  parser_enable <= 1'b1;
                  hold_cnt      <= HOLD_ONE;
                  state         <= ST_STREAM;
               end else if (eof_now && !inflight) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            // Pause blocks both advance and the end-of-document exit.
            ST_STREAM: begin
               if (fifo_pop) begin
                  char     <= fifo_head;
                  hold_cnt <= HOLD_ONE;
               end else if (hold_met && !pause && fifo_empty && eof_now && !inflight) begin
                  state         <= ST_DONE;
                  parser_enable <= 1'b0;
                  char          <= '0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end else if (!hold_met) begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_html_char_streamer.sv
// Self-checking bench: directed scenarios plus randomized documents checked
// against a filtered-byte-sequence model of the document.
`timescale 1ns/1ps
module tb_html_char_streamer;

   localparam int AW    = 6;
   localparam int LEN_A = 64;
   localparam int LEN_B = 3;
   localparam int HOLD  = 2;

   logic          clock = 1'b0;
   logic          resetn;
   logic          start;
   logic          pause;
   logic          sel;
   logic          start_a;
   logic          start_b;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [7:0]    data_a;
   logic [7:0]    data_b;
   logic [7:0]    char_a;
   logic [7:0]    char_b;
   logic          pe_a, pe_b, busy_a, busy_b, done_a, done_b;

   logic [7:0]    obs_char;
   logic [AW-1:0] obs_addr;
   logic          obs_pe, obs_busy, obs_done;

   logic [7:0]    rom [0:63];
   logic [7:0]    exp_q [$];
   logic [7:0]    seen_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   assign data_a   = rom[addr_a];
   assign data_b   = rom[addr_b];
   assign start_a  = start & ~sel;
   assign start_b  = start & sel;
   assign obs_char = sel ? char_b : char_a;
   assign obs_addr = sel ? addr_b : addr_a;
   assign obs_pe   = sel ? pe_b   : pe_a;
   assign obs_busy = sel ? busy_b : busy_a;
   assign obs_done = sel ? done_b : done_a;

   html_char_streamer #(.ADDR_WIDTH(AW), .DOC_LENGTH(LEN_A), .MIN_HOLD(HOLD)) dut_a (
      .clock(clock), .resetn(resetn), .start(start_a), .pause(pause),
      .mem_addr(addr_a), .mem_data(data_a), .char(char_a),
      .parser_enable(pe_a), .busy(busy_a), .done(done_a)
   );

   html_char_streamer #(.ADDR_WIDTH(AW), .DOC_LENGTH(LEN_B), .MIN_HOLD(HOLD)) dut_b (
      .clock(clock), .resetn(resetn), .start(start_b), .pause(pause),
      .mem_addr(addr_b), .mem_data(data_b), .char(char_b),
      .parser_enable(pe_b), .busy(busy_b), .done(done_b)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected presentation order: bytes up to NUL or the length limit, minus CR/LF/TAB.
   task automatic buildExpected();
      int lim;
      lim = sel ? LEN_B : LEN_A;
      exp_q.delete();
      for (int i = 0; i < lim; i++) begin
         if (rom[i] == 8'h00) break;
         if (rom[i] != 8'h0D && rom[i] != 8'h0A && rom[i] != 8'h09)
            exp_q.push_back(rom[i]);
      end
   endtask

   // '~' = CR, '^' = LF, '|' = TAB; remaining bytes are NUL or filler 'q'.
   task automatic applyStimulus(input string doc, input bit add_nul, input bit use_b);
      logic [7:0] c;
      sel = use_b;
      for (int i = 0; i < 64; i++) rom[i] = add_nul ? 8'h00 : 8'h71;
      for (int i = 0; i < doc.len(); i++) begin
         c = doc[i];
         case (c)
            8'h7E:   rom[i] = 8'h0D;
            8'h5E:   rom[i] = 8'h0A;
            8'h7C:   rom[i] = 8'h09;
            default: rom[i] = c;
         endcase
      end
      buildExpected();
   endtask

   task automatic randomDoc();
      string      pool;
      int         n;
      logic [7:0] prev;
      logic [7:0] c;
      pool = "<a>b/ =cd";
      sel  = 1'b0;
      n    = $urandom_range(70, 1);
      prev = 8'h00;
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(99) < 20) begin
            case ($urandom_range(2))
               0:       rom[i] = 8'h0D;
               1:       rom[i] = 8'h0A;
               default: rom[i] = 8'h09;
            endcase
         end else begin
            c = pool[$urandom_range(pool.len() - 1)];
            while (c == prev) c = pool[$urandom_range(pool.len() - 1)];
            rom[i] = c;
            prev   = c;
         end
      end
      if (n < 64) rom[n] = 8'h00;
      buildExpected();
   endtask

   task automatic waitDone(input string tag, input int budget);
      bit fin;
      fin = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         step();
         if (obs_done) fin = 1'b1;
      end
      checkOutput({tag, "_done"}, fin, 1);
      checkOutput({tag, "_end_pe"}, obs_pe, 0);
      checkOutput({tag, "_end_char"}, obs_char, 0);
   endtask

   // Exact-timing pass with no pause: char k shown for cycles 2+HOLD*k .. 2+HOLD*k+HOLD-1.
   task automatic runTimed(input string tag, input int restart_cycle);
      int         n;
      int         last_c;
      logic [7:0] exp_char;
      logic       exp_pe;
      n      = exp_q.size();
      last_c = 2 + HOLD * n + 1;
      pause  = 1'b0;
      for (int c = 0; c <= last_c; c++) begin
         start = (c == 0) || (c == restart_cycle);
         step();
         start    = 1'b0;
         exp_pe   = (c >= 2) && (c < 2 + HOLD * n);
         exp_char = exp_pe ? exp_q[(c - 2) / HOLD] : 8'h00;
         checkOutput({tag, "_char"}, obs_char, exp_char);
         checkOutput({tag, "_pe"}, obs_pe, exp_pe);
         checkOutput({tag, "_done"}, obs_done, c >= 2 + HOLD * n);
         if (c == restart_cycle) checkOutput({tag, "_addr_kept"}, obs_addr != 0, 1);
      end
   endtask

   // Untimed pass: records each new presented char and checks hold length and pause rule.
   task automatic runPass(input string tag, input int pause_pct);
      int         hold;
      logic [7:0] last;
      bit         shown, pe_seen, pause_at_edge, fin;
      hold = 0; last = 8'h00; shown = 1'b0; pe_seen = 1'b0; fin = 1'b0;
      seen_q.delete();
      pause = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 3000 && !fin; c++) begin
         pause_at_edge = pause;
         step();
         start = 1'b0;
         if (obs_pe) begin
            pe_seen = 1'b1;
            if (!shown || obs_char != last) begin
               if (shown) begin
                  checkOutput({tag, "_hold"}, hold >= HOLD, 1);
                  checkOutput({tag, "_pause"}, pause_at_edge, 0);
               end
               seen_q.push_back(obs_char);
               last  = obs_char;
               shown = 1'b1;
               hold  = 1;
            end else begin
               hold++;
            end
         end
         if (obs_done) begin
            fin = 1'b1;
            if (shown) begin
               checkOutput({tag, "_last_hold"}, hold >= HOLD, 1);
               checkOutput({tag, "_last_pause"}, pause_at_edge, 0);
            end
         end
         pause = ($urandom_range(99) < pause_pct);
      end
      pause = 1'b0;
      checkOutput({tag, "_finished"}, fin, 1);
      checkOutput({tag, "_len"}, seen_q.size(), exp_q.size());
      for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
         checkOutput({tag, "_seq"}, seen_q[i], exp_q[i]);
      checkOutput({tag, "_pe_seen"}, pe_seen, exp_q.size() != 0);
      checkOutput({tag, "_end_pe"}, obs_pe, 0);
      checkOutput({tag, "_end_char"}, obs_char, 0);
      checkOutput({tag, "_end_busy"}, obs_busy, 0);
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      pause  = 1'b0;
      sel    = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = 8'h00;
      step(); step(); step();
      checkOutput("rst_addr", obs_addr, 0);
      checkOutput("rst_char", obs_char, 0);
      checkOutput("rst_pe", obs_pe, 0);
      checkOutput("rst_busy", obs_busy, 0);
      checkOutput("rst_done", obs_done, 0);
      resetn = 1'b1;
      step();

      applyStimulus("ab", 1'b1, 1'b0);
      runTimed("basic", -1);

      applyStimulus("abcd", 1'b1, 1'b0);
      runTimed("restart", 5);

      applyStimulus("a~^b", 1'b1, 1'b0);
      runPass("ws", 0);

      applyStimulus("xy", 1'b1, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      checkOutput("pause_first", obs_char, 8'h78);
      step();
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         checkOutput("pause_hold", obs_char, 8'h78);
      end
      pause = 1'b0;
      step();
      checkOutput("pause_release", obs_char, 8'h79);
      waitDone("pause", 20);

      applyStimulus("", 1'b1, 1'b0);
      runPass("empty", 0);

      applyStimulus("abcd", 1'b0, 1'b1);
      runPass("doclen", 0);
      sel = 1'b0;

      applyStimulus("ab", 1'b1, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      checkOutput("midrst_b", obs_char, 8'h62);
      resetn = 1'b0;
      step();
      checkOutput("midrst_addr", obs_addr, 0);
      checkOutput("midrst_char", obs_char, 0);
      checkOutput("midrst_pe", obs_pe, 0);
      checkOutput("midrst_busy", obs_busy, 0);
      checkOutput("midrst_done", obs_done, 0);
      step();
      checkOutput("midrst_noread", obs_addr, 0);
      resetn = 1'b1;
      step();
      runPass("replay", 0);

      for (int r = 0; r < 8; r++) begin
         randomDoc();
         runPass($sformatf("rand%0d", r), $urandom_range(50));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
